msg_word_packer: RTL
====================

// Module: msg_word_packer
// PURPOSE
//  Downstream of the serial message receiver: consumes its byte stream (msg_in/data_valid) plus frame-type
//  flags and packs bytes MSB-first into WORD_BYTES-wide words. Each completed word is written to particle or
//  map memory with a one-cycle write strobe and an auto-incrementing per-type address. Also flags end of
//  frame and truncated frames.
// PARAMETERS
//  WORD_BYTES      4   bytes per output word (>=1)
//  PARTICLE_WORDS  2   words per particle frame (frame bytes = PARTICLE_WORDS*WORD_BYTES, must equal upstream length)
//  MAP_WORDS       4   words per map frame
//  ADDR_WIDTH      8   width of both write-address counters
// PORTS
//  clk                 in   1               system clock, all logic on rising edge
//  rst                 in   1               asynchronous reset, active-high
//  msg_in              in   8               data byte from receiver
//  data_valid          in   1               level; high >=1 cycle per byte; byte accepted on 0->1 edge only
//  particle_data_flag  in   1               high for whole particle frame
//  map_data_flag       in   1               high for whole map frame
//  wr_data             out  8*WORD_BYTES    packed word, first byte in MSBs
//  wr_addr             out  ADDR_WIDTH      address for wr_data
//  particle_wr_en      out  1               1-cycle write strobe, particle memory
//  map_wr_en           out  1               1-cycle write strobe, map memory
//  frame_done          out  1               1-cycle pulse, last word of frame written
//  frame_err           out  1               1-cycle pulse, frame truncated
//  checksum            out  8               frame XOR checksum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, any state): all outputs 0, state IDLE, byte/word counters 0, both address counters 0, edge reg 0.
//  - Byte accept: dv_q <= data_valid each cycle; accept when data_valid && !dv_q. A level held N cycles = 1 byte.
//  - States: IDLE, COLLECT, WRITE.
//    IDLE: particle_data_flag -> COLLECT, type=PARTICLE; else map_data_flag -> COLLECT, type=MAP;
//      both high -> PARTICLE wins. Load word counter with PARTICLE_WORDS/MAP_WORDS, clear byte counter.
//    COLLECT: on accepted byte, shift into word buffer (shift left by 8, byte into LSBs), byte_cnt+1.
//      On byte WORD_BYTES-1 accepted: -> WRITE next cycle.
//      Active-type flag low while in COLLECT: discard partial word, pulse frame_err, -> IDLE; no write.
//    WRITE (1 cycle): wr_data=buffer, wr_addr=current type's address counter, strobe matching wr_en;
//      increment that address counter (wraps 2^ADDR_WIDTH-1 -> 0, no error); word counter-1.
//      Word counter reaches 0 -> pulse frame_done same cycle, -> IDLE; else -> COLLECT, byte_cnt=0.
//  - Latency: last byte's accepting edge -> wr_en 1 cycle later (registered). Max 1 word per WORD_BYTES+1 cycles.
//  - Accepted edge in WRITE cycle: held; buffered into next word, not lost.
//  - Flag drop in WRITE: write completes; truncation seen in following COLLECT -> frame_err.
//  - Extra bytes after frame_done while flag still high: ignored in IDLE until flag falls and rises again
//    (IDLE re-arms only after both flags seen low once).
//  - Address counters are independent and persist across frames; cleared only by rst.
//  - wr_data/wr_addr hold last value between strobes; consumers sample only on wr_en.
//  - particle_wr_en, map_wr_en never high together; frame_done and frame_err never high together.
// CONFIGURATION
//  MSG_WORD_PACKER_CHECKSUM_EN defined: running XOR of all accepted frame bytes, cleared on leaving IDLE;
//    checksum valid in frame_done cycle, held until next frame starts. frame_err clears it to 0.
//  Not defined: checksum tied to 8'h00, no XOR logic synthesized.
// TESTING
//  1 Reset: assert rst mid-COLLECT with 2 bytes in -> all outputs 0 immediately; next particle frame writes addr 0.
//  2 Particle frame 11 22 33 44 55 66 77 88, defaults -> particle_wr_en twice: 0x11223344@0, 0x55667788@1;
//    frame_done with 2nd write; checksum 0x88 with macro, 0x00 without.
//  3 data_valid held 3 cycles per byte, map frame 16 bytes -> exactly 4 map writes at map addr 0..3,
//    particle addr stays 0.
//  4 Truncation: particle flag drops after 3 bytes -> frame_err 1 cycle, no wr_en; next frame starts at word 0.
//  5 ADDR_WIDTH=2, 3 particle frames -> addresses 0,1,2,3,0,1 with no error.
//  6 Both flags rise same cycle -> treated as particle; map_wr_en never asserted.

Source files
------------

// File: rtl/msg_word_packer.sv
`timescale 1ns/1ps
// msg_word_packer
//   Packs the receiver byte stream MSB-first into WORD_BYTES-wide words and
//   writes each word to particle or map memory with a one-cycle strobe and a
//   per-type auto-incrementing address. Flags end of frame and truncation.
//   Optional feature macro: MSG_WORD_PACKER_CHECKSUM_EN (running frame XOR).
module msg_word_packer #(
   parameter int WORD_BYTES     = 4,
   parameter int PARTICLE_WORDS = 2,
   parameter int MAP_WORDS      = 4,
   parameter int ADDR_WIDTH     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              msg_in,
   input  logic                    data_valid,
   input  logic                    particle_data_flag,
   input  logic                    map_data_flag,
   output logic [8*WORD_BYTES-1:0] wr_data,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic                    particle_wr_en,
   output logic                    map_wr_en,
   output logic                    frame_done,
   output logic                    frame_err,
   output logic [7:0]              checksum
);

   localparam int WW   = 8 * WORD_BYTES;
   localparam int MAXW = (PARTICLE_WORDS > MAP_WORDS) ? PARTICLE_WORDS : MAP_WORDS;
   localparam int WC_W = $clog2(MAXW + 1);
   localparam int BC_W = $clog2(WORD_BYTES + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

   state_t              state_reg, state_next;
   logic                dv_q;
   logic                armed_reg;
   logic                type_map_reg;
   logic [BC_W-1:0]     byte_cnt_reg;
   logic [WC_W-1:0]     word_cnt_reg;
   logic [WW-1:0]       buf_reg;
   logic                pend_valid_reg;
   logic [7:0]          pend_byte_reg;
   logic [ADDR_WIDTH-1:0] part_addr_reg, map_addr_reg;

   logic [WW-1:0]         wr_data_reg;
   logic [ADDR_WIDTH-1:0] wr_addr_reg;
   logic                  particle_wr_en_reg, map_wr_en_reg;
   logic                  frame_done_reg, frame_err_reg;

   // combinational controls
   logic          accept;
   logic          active_flag;
   logic          last_word;
   logic          start, start_map, take, word_done, trunc, pend_set;
   logic [7:0]    take_byte;
   logic [WW-1:0] word_next;

   assign accept      = data_valid && !dv_q;
   assign active_flag = type_map_reg ? map_data_flag : particle_data_flag;
   assign last_word   = (word_cnt_reg == WC_W'(1));
   assign word_next   = (buf_reg << 8) | WW'(take_byte);

   // State register, data_valid edge detector and the IDLE re-arm latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         dv_q      <= 1'b0;
         armed_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         dv_q      <= data_valid;
         // a new frame may start only after both flags have been seen low
         if (!particle_data_flag && !map_data_flag)
            armed_reg <= 1'b1;
         else if (state_reg == WRITE && last_word)
            armed_reg <= 1'b0;
      end
   end

   // Next-state logic and per-cycle datapath controls
   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      start_map  = 1'b0;
      take       = 1'b0;
      take_byte  = msg_in;
      word_done  = 1'b0;
      trunc      = 1'b0;
      pend_set   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (armed_reg && (particle_data_flag || map_data_flag)) begin
               start      = 1'b1;
               start_map  = !particle_data_flag;   // particle wins a tie
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            if (!active_flag) begin
               trunc      = 1'b1;
               state_next = IDLE;
            end else if (pend_valid_reg || accept) begin
               take = 1'b1;
               if (pend_valid_reg)
                  take_byte = pend_byte_reg;
               if (byte_cnt_reg == BC_W'(WORD_BYTES - 1)) begin
                  word_done  = 1'b1;
                  state_next = WRITE;
               end
            end
         end
         WRITE: begin
            if (last_word) begin
               state_next = IDLE;
            end else begin
               state_next = COLLECT;
               pend_set   = accept;   // byte arriving during the write is kept
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Word assembly, counters and address counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         type_map_reg   <= 1'b0;
         byte_cnt_reg   <= '0;
         word_cnt_reg   <= '0;
         buf_reg        <= '0;
         pend_valid_reg <= 1'b0;
         pend_byte_reg  <= 8'h00;
         part_addr_reg  <= '0;
         map_addr_reg   <= '0;
      end else begin
         if (start) begin
            type_map_reg   <= start_map;
            word_cnt_reg   <= start_map ? WC_W'(MAP_WORDS) : WC_W'(PARTICLE_WORDS);
            byte_cnt_reg   <= '0;
            buf_reg        <= '0;
            pend_valid_reg <= 1'b0;
         end
         if (trunc) begin
            byte_cnt_reg   <= '0;
            buf_reg        <= '0;
            pend_valid_reg <= 1'b0;
         end
         if (take) begin
            buf_reg        <= word_next;
            byte_cnt_reg   <= byte_cnt_reg + 1'b1;
            pend_valid_reg <= 1'b0;
         end
         if (word_done)
            byte_cnt_reg <= '0;
         if (state_reg == WRITE) begin
            word_cnt_reg <= word_cnt_reg - 1'b1;
            if (type_map_reg)
               map_addr_reg <= map_addr_reg + 1'b1;
            else
               part_addr_reg <= part_addr_reg + 1'b1;
         end
         if (pend_set) begin
            pend_valid_reg <= 1'b1;
            pend_byte_reg  <= msg_in;
         end
      end
   end

   // Registered write port and status pulses; data/address hold between strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_data_reg        <= '0;
         wr_addr_reg        <= '0;
         particle_wr_en_reg <= 1'b0;
         map_wr_en_reg      <= 1'b0;
         frame_done_reg     <= 1'b0;
         frame_err_reg      <= 1'b0;
      end else begin
         particle_wr_en_reg <= 1'b0;
         map_wr_en_reg      <= 1'b0;
         frame_done_reg     <= 1'b0;
         frame_err_reg      <= trunc;
         if (word_done) begin
            wr_data_reg        <= word_next;
            wr_addr_reg        <= type_map_reg ? map_addr_reg : part_addr_reg;
            particle_wr_en_reg <= !type_map_reg;
            map_wr_en_reg      <= type_map_reg;
            frame_done_reg     <= last_word;
         end
      end
   end

   assign wr_data        = wr_data_reg;
   assign wr_addr        = wr_addr_reg;
   assign particle_wr_en = particle_wr_en_reg;
   assign map_wr_en      = map_wr_en_reg;
   assign frame_done     = frame_done_reg;
   assign frame_err      = frame_err_reg;

`ifdef MSG_WORD_PACKER_CHECKSUM_EN
   logic [7:0] csum_reg;

   // Running XOR of frame bytes; restarts with each frame, zeroed on truncation
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         csum_reg <= 8'h00;
      else if (start || trunc)
         csum_reg <= 8'h00;
      else if (take)
         csum_reg <= csum_reg ^ take_byte;
   end

   assign checksum = csum_reg;
`else
   assign checksum = 8'h00;
`endif

endmodule
